// File: rtl/vx_cache_flush_walker.sv
// vx_cache_flush_walker: per-bank flush sequencer for a writeback cache tag store.
// Walks every (set, way) in order and invalidates it through the tag-store flush
// port. Each dirty eviction reported by the tag store becomes exactly one line
// writeback request. Completion is reported with the number of lines written back.
module vx_cache_flush_walker #(
    parameter int CACHE_SIZE = 1024,
    parameter int LINE_SIZE  = 16,
    parameter int NUM_BANKS  = 1,
    parameter int NUM_WAYS   = 1,
    parameter int WORD_SIZE  = 1,
    localparam int CS_LINES_PER_BANK  = CACHE_SIZE / (LINE_SIZE * NUM_BANKS * NUM_WAYS),
    localparam int CS_LINE_SEL_BITS   = $clog2(CS_LINES_PER_BANK),
    localparam int CS_WORD_ADDR_WIDTH = 32 - $clog2(WORD_SIZE),
    localparam int CS_WORD_SEL_BITS   = $clog2(LINE_SIZE / WORD_SIZE),
    localparam int CS_BANK_SEL_BITS   = $clog2(NUM_BANKS),
    localparam int CS_LINE_ADDR_WIDTH = CS_WORD_ADDR_WIDTH - CS_WORD_SEL_BITS - CS_BANK_SEL_BITS,
    localparam int CS_TAG_SEL_BITS    = CS_LINE_ADDR_WIDTH - CS_LINE_SEL_BITS,
    localparam int CW                 = $clog2(CS_LINES_PER_BANK * NUM_WAYS + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush_req_valid,
    output logic                          flush_req_ready,
    output logic                          flush_rsp_valid,
    input  logic                          flush_rsp_ready,
    output logic [CW-1:0]                 flush_rsp_wb_count,
    output logic                          flush_line,
    output logic [NUM_WAYS-1:0]           flush_way_sel,
    output logic [CS_LINE_SEL_BITS-1:0]   flush_line_sel,
    input  logic                          flush_stall,
    input  logic                          eviction,
    input  logic [CS_TAG_SEL_BITS-1:0]    evicted_tag,
    output logic                          wb_req_valid,
    input  logic                          wb_req_ready,
    output logic [CS_LINE_ADDR_WIDTH-1:0] wb_req_line_addr,
    output logic [NUM_WAYS-1:0]           wb_req_way,
    output logic                          busy
);

    // With a single way the way counter still needs one bit; it simply never moves.
    localparam int WAY_BITS = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    localparam logic [WAY_BITS-1:0]           WAY_ZERO    = {WAY_BITS{1'b0}};
    localparam logic [WAY_BITS-1:0]           WAY_ONE     = WAY_BITS'(1'b1);
    localparam logic [WAY_BITS-1:0]           WAY_LAST    = WAY_BITS'(NUM_WAYS - 1);
    localparam logic [CS_LINE_SEL_BITS-1:0]   SET_ZERO    = {CS_LINE_SEL_BITS{1'b0}};
    localparam logic [CS_LINE_SEL_BITS-1:0]   SET_ONE     = CS_LINE_SEL_BITS'(1'b1);
    localparam logic [CS_LINE_SEL_BITS-1:0]   SET_LAST    = CS_LINE_SEL_BITS'(CS_LINES_PER_BANK - 1);
    localparam logic [NUM_WAYS-1:0]           WSEL_ZERO   = {NUM_WAYS{1'b0}};
    localparam logic [NUM_WAYS-1:0]           WSEL_ONE    = NUM_WAYS'(1'b1);
    localparam logic [CW-1:0]                 CNT_ZERO    = {CW{1'b0}};
    localparam logic [CW-1:0]                 CNT_ONE     = CW'(1'b1);
    localparam logic [CS_LINE_ADDR_WIDTH-1:0] ADDR_ZERO   = {CS_LINE_ADDR_WIDTH{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WB    = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                        state_r;
    logic [CS_LINE_SEL_BITS-1:0]   set_r;
    logic [WAY_BITS-1:0]           way_r;
    logic [CS_LINE_SEL_BITS-1:0]   next_set_s;
    logic [WAY_BITS-1:0]           next_way_s;
    logic [NUM_WAYS-1:0]           next_way_sel_s;
    logic                          last_entry_s;

    // Next walk position: ways of a set first, then the following set
    always_comb begin
        next_set_s = set_r;
        next_way_s = way_r;
        if (way_r == WAY_LAST) begin
            next_way_s = WAY_ZERO;
            next_set_s = set_r + SET_ONE;
        end else begin
            next_way_s = way_r + WAY_ONE;
            next_set_s = set_r;
        end
    end

    assign last_entry_s   = (way_r == WAY_LAST) && (set_r == SET_LAST);
    assign next_way_sel_s = WSEL_ONE << next_way_s;

    // Walk FSM: state, walk position and every output are registered here
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r            <= ST_IDLE;
            set_r              <= SET_ZERO;
            way_r              <= WAY_ZERO;
            flush_req_ready    <= 1'b1;
            flush_rsp_valid    <= 1'b0;
            flush_rsp_wb_count <= CNT_ZERO;
            flush_line         <= 1'b0;
            flush_way_sel      <= WSEL_ZERO;
            flush_line_sel     <= SET_ZERO;
            wb_req_valid       <= 1'b0;
            wb_req_line_addr   <= ADDR_ZERO;
            wb_req_way         <= WSEL_ZERO;
            busy               <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (flush_req_valid) begin
                        state_r            <= ST_ISSUE;
                        set_r              <= SET_ZERO;
                        way_r              <= WAY_ZERO;
                        flush_rsp_wb_count <= CNT_ZERO;
                        flush_req_ready    <= 1'b0;
                        busy               <= 1'b1;
                        flush_line         <= 1'b1;
                        flush_way_sel      <= WSEL_ONE;
                        flush_line_sel     <= SET_ZERO;
                    end
                end
                ST_ISSUE: begin
                    // A stalled access is simply retried with everything held.
                    if (!flush_stall) begin
                        if (eviction) begin
                            state_r            <= ST_WB;
                            flush_rsp_wb_count <= flush_rsp_wb_count + CNT_ONE;
                            wb_req_line_addr   <= {evicted_tag, set_r};
                            wb_req_way         <= flush_way_sel;
                            wb_req_valid       <= 1'b1;
                            flush_line         <= 1'b0;
                            flush_way_sel      <= WSEL_ZERO;
                            flush_line_sel     <= SET_ZERO;
                        end else if (last_entry_s) begin
                            state_r         <= ST_DONE;
                            flush_line      <= 1'b0;
                            flush_way_sel   <= WSEL_ZERO;
                            flush_line_sel  <= SET_ZERO;
                            flush_rsp_valid <= 1'b1;
                        end else begin
                            set_r          <= next_set_s;
                            way_r          <= next_way_s;
                            flush_way_sel  <= next_way_sel_s;
                            flush_line_sel <= next_set_s;
                        end
                    end
                end
                ST_WB: begin
                    // set_r/way_r still name the evicted entry, so advancing resumes the walk.
                    if (wb_req_ready) begin
                        wb_req_valid <= 1'b0;
                        if (last_entry_s) begin
                            state_r         <= ST_DONE;
                            flush_rsp_valid <= 1'b1;
                        end else begin
                            state_r        <= ST_ISSUE;
                            set_r          <= next_set_s;
                            way_r          <= next_way_s;
                            flush_line     <= 1'b1;
                            flush_way_sel  <= next_way_sel_s;
                            flush_line_sel <= next_set_s;
                        end
                    end
                end
                ST_DONE: begin
                    if (flush_rsp_ready) begin
                        state_r         <= ST_IDLE;
                        flush_rsp_valid <= 1'b0;
                        flush_req_ready <= 1'b1;
                        busy            <= 1'b0;
                    end
                end
                default: begin
                    state_r         <= ST_IDLE;
                    flush_req_ready <= 1'b1;
                    flush_rsp_valid <= 1'b0;
                    flush_line      <= 1'b0;
                    flush_way_sel   <= WSEL_ZERO;
                    flush_line_sel  <= SET_ZERO;
                    wb_req_valid    <= 1'b0;
                    busy            <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vx_cache_flush_walker.sv
// Directed, self-checking bench for vx_cache_flush_walker.
// dut_a: 2 ways, 32 sets. dut_b: 1 way, 32 sets. Expected accesses, writebacks
// and completion counts are queued when stimulus is decided and popped when the
// DUT shows the matching activity.
module tb_vx_cache_flush_walker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        flush_rsp_ready;
    logic        flush_stall;
    logic        eviction;
    logic [22:0] evicted_tag;
    logic        wb_req_ready;

    logic        a_req_valid, a_req_ready, a_rsp_valid, a_line, a_wb_valid, a_busy;
    logic [6:0]  a_wb_count;
    logic [1:0]  a_way_sel, a_wb_way;
    logic [4:0]  a_line_sel;
    logic [27:0] a_wb_addr;

    logic        b_req_valid, b_req_ready, b_rsp_valid, b_line, b_wb_valid, b_busy;
    logic [5:0]  b_wb_count;
    logic [0:0]  b_way_sel, b_wb_way;
    logic [4:0]  b_line_sel;
    logic [27:0] b_wb_addr;

    vx_cache_flush_walker #(.CACHE_SIZE(1024), .LINE_SIZE(16), .NUM_BANKS(1),
                            .NUM_WAYS(2), .WORD_SIZE(1)) dut_a (
        .clk(clk), .reset(reset),
        .flush_req_valid(a_req_valid), .flush_req_ready(a_req_ready),
        .flush_rsp_valid(a_rsp_valid), .flush_rsp_ready(flush_rsp_ready),
        .flush_rsp_wb_count(a_wb_count),
        .flush_line(a_line), .flush_way_sel(a_way_sel), .flush_line_sel(a_line_sel),
        .flush_stall(flush_stall), .eviction(eviction), .evicted_tag(evicted_tag),
        .wb_req_valid(a_wb_valid), .wb_req_ready(wb_req_ready),
        .wb_req_line_addr(a_wb_addr), .wb_req_way(a_wb_way), .busy(a_busy));

    vx_cache_flush_walker #(.CACHE_SIZE(512), .LINE_SIZE(16), .NUM_BANKS(1),
                            .NUM_WAYS(1), .WORD_SIZE(1)) dut_b (
        .clk(clk), .reset(reset),
        .flush_req_valid(b_req_valid), .flush_req_ready(b_req_ready),
        .flush_rsp_valid(b_rsp_valid), .flush_rsp_ready(flush_rsp_ready),
        .flush_rsp_wb_count(b_wb_count),
        .flush_line(b_line), .flush_way_sel(b_way_sel), .flush_line_sel(b_line_sel),
        .flush_stall(flush_stall), .eviction(eviction), .evicted_tag(evicted_tag),
        .wb_req_valid(b_wb_valid), .wb_req_ready(wb_req_ready),
        .wb_req_line_addr(b_wb_addr), .wb_req_way(b_wb_way), .busy(b_busy));

    // Observed view of whichever DUT is under test
    logic        use_b;
    logic        o_req_ready, o_rsp_valid, o_line, o_wb_valid, o_busy;
    logic [6:0]  o_wb_count;
    logic [1:0]  o_way_sel, o_wb_way;
    logic [4:0]  o_line_sel;
    logic [27:0] o_wb_addr;

    // Select the observed DUT outputs
    always_comb begin
        o_req_ready = a_req_ready; o_rsp_valid = a_rsp_valid; o_line = a_line;
        o_wb_valid = a_wb_valid; o_busy = a_busy; o_wb_count = a_wb_count;
        o_way_sel = a_way_sel; o_wb_way = a_wb_way; o_line_sel = a_line_sel;
        o_wb_addr = a_wb_addr;
        if (use_b) begin
            o_req_ready = b_req_ready; o_rsp_valid = b_rsp_valid; o_line = b_line;
            o_wb_valid = b_wb_valid; o_busy = b_busy; o_wb_count = {1'b0, b_wb_count};
            o_way_sel = {1'b0, b_way_sel}; o_wb_way = {1'b0, b_wb_way};
            o_line_sel = b_line_sel; o_wb_addr = b_wb_addr;
        end else begin
            o_req_ready = a_req_ready;
        end
    end

    int tests = 0;
    int fails = 0;
    logic [31:0] acc_q[$];
    logic [63:0] wb_q[$];
    int          cnt_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full walk on the selected DUT, reacting cycle by cycle.
    // stall_mode 1: stall the first ISSUE cycle of every access.
    // evict_mode 1: only set 5 way 1 (tag 0x3A); 2: every access.
    task automatic do_walk(input bit hold_req, input int stall_mode, input int evict_mode,
                           input int wb_hold, input int exp_cycles, input int rsp_hold);
        int          ways, cyc, wb_wait, exp_count, got_count;
        bit          stall_tog, done;
        logic [31:0] acc;
        logic [63:0] wbe;
        logic [4:0]  s;
        logic [1:0]  wsel;
        logic [22:0] tag;
        ways = use_b ? 1 : 2;
        exp_count = 0;
        for (int si = 0; si < 32; si++) begin
            for (int wi = 0; wi < ways; wi++) begin
                acc_q.push_back({si[15:0], wi[15:0]});
                if (evict_mode == 2 || (evict_mode == 1 && si == 5 && wi == 1)) exp_count++;
            end
        end
        cnt_q.push_back(exp_count);
        check("start_ready", 64'(o_req_ready), 64'(1));
        check("start_busy", 64'(o_busy), 64'(0));
        if (use_b) b_req_valid = 1'b1; else a_req_valid = 1'b1;
        cyc = 0; wb_wait = 0; stall_tog = 1'b0; done = 1'b0;
        while (!done) begin
            tick();
            cyc++;
            if (!hold_req) begin a_req_valid = 1'b0; b_req_valid = 1'b0; end
            flush_stall = 1'b0; eviction = 1'b0; wb_req_ready = 1'b0;
            if (cyc > 400) begin
                check("walk_timeout", 64'(o_rsp_valid), 64'(1));
                done = 1'b1;
            end else if (o_line) begin
                check("line_excl_wb", 64'(o_wb_valid), 64'(0));
                check("walk_busy_ready", 64'({o_busy, o_req_ready}), 64'(2'b10));
                if (stall_mode == 1 && !stall_tog) begin
                    flush_stall = 1'b1;
                    stall_tog = 1'b1;
                end else if (acc_q.size() == 0) begin
                    check("extra_access", 64'(o_line), 64'(0));
                end else begin
                    stall_tog = 1'b0;
                    acc = acc_q.pop_front();
                    s = acc[20:16];
                    wsel = 2'b01 << acc[1:0];
                    check("line_sel", 64'(o_line_sel), 64'(s));
                    check("way_sel", 64'(o_way_sel), 64'(wsel));
                    if (evict_mode == 2 || (evict_mode == 1 && s == 5'd5 && wsel == 2'b10)) begin
                        tag = (evict_mode == 1) ? 23'h3A : ({18'h0, s} ^ 23'h5A5A5);
                        eviction = 1'b1;
                        evicted_tag = tag;
                        wb_q.push_back(64'({wsel, tag, s}));
                    end
                end
            end else if (o_wb_valid) begin
                check("wb_busy", 64'(o_busy), 64'(1));
                if (wb_q.size() == 0) begin
                    check("extra_wb", 64'(o_wb_valid), 64'(0));
                end else begin
                    wbe = wb_q[0];
                    check("wb_addr", 64'(o_wb_addr), 64'(wbe[27:0]));
                    check("wb_way", 64'(o_wb_way), 64'(wbe[29:28]));
                    if (wb_wait >= wb_hold) begin
                        wb_req_ready = 1'b1;
                        wb_wait = 0;
                        wbe = wb_q.pop_front();
                    end else begin
                        wb_wait++;
                    end
                end
            end else if (o_rsp_valid) begin
                got_count = cnt_q.pop_front();
                check("done_cycle", 64'(cyc), 64'(exp_cycles));
                check("wb_count", 64'(o_wb_count), 64'(got_count));
                check("done_req_ready", 64'(o_req_ready), 64'(0));
                check("accesses_left", 64'(acc_q.size()), 64'(0));
                check("wbs_left", 64'(wb_q.size()), 64'(0));
                for (int k = 0; k < rsp_hold; k++) begin
                    tick();
                    check("rsp_held", 64'(o_rsp_valid), 64'(1));
                    check("rsp_count_held", 64'(o_wb_count), 64'(got_count));
                end
                flush_rsp_ready = 1'b1;
                tick();
                flush_rsp_ready = 1'b0;
                check("rsp_dropped", 64'(o_rsp_valid), 64'(0));
                check("idle_ready", 64'(o_req_ready), 64'(1));
                check("idle_busy", 64'(o_busy), 64'(0));
                done = 1'b1;
            end else begin
                check("walk_stuck_idle", 64'(o_busy), 64'(1));
                done = 1'b1;
            end
        end
        acc_q.delete();
        wb_q.delete();
    endtask

    initial begin
        bit found;
        use_b = 1'b0;
        reset = 1'b1;
        a_req_valid = 1'b0; b_req_valid = 1'b0;
        flush_rsp_ready = 1'b0; flush_stall = 1'b0; eviction = 1'b0;
        evicted_tag = 23'h0; wb_req_ready = 1'b0;
        #2 reset = 1'b0;
        tick(); tick();

        // Reset values
        check("rst_req_ready", 64'(a_req_ready), 64'(1));
        check("rst_rsp_valid", 64'(a_rsp_valid), 64'(0));
        check("rst_flush_line", 64'(a_line), 64'(0));
        check("rst_way_sel", 64'(a_way_sel), 64'(0));
        check("rst_line_sel", 64'(a_line_sel), 64'(0));
        check("rst_wb_valid", 64'(a_wb_valid), 64'(0));
        check("rst_wb_addr", 64'(a_wb_addr), 64'(0));
        check("rst_wb_way", 64'(a_wb_way), 64'(0));
        check("rst_wb_count", 64'(a_wb_count), 64'(0));
        check("rst_busy", 64'(a_busy), 64'(0));
        check("rst_b_req_ready", 64'(b_req_ready), 64'(1));
        reset = 1'b1;
        tick();

        // Clean walk, one eviction with slow writeback, alternate stalls
        do_walk(1'b0, 0, 0, 0, 65, 0);
        do_walk(1'b0, 0, 1, 3, 69, 0);
        do_walk(1'b0, 1, 0, 0, 129, 0);

        // Request held high through the walk, response back-pressured
        do_walk(1'b1, 0, 0, 0, 65, 4);
        tick();
        check("second_walk_line", 64'(a_line), 64'(1));
        check("second_walk_set", 64'(a_line_sel), 64'(0));
        check("second_walk_way", 64'(a_way_sel), 64'(2'b01));
        check("second_walk_ready", 64'(a_req_ready), 64'(0));
        a_req_valid = 1'b0;
        for (int k = 0; k < 200 && !a_rsp_valid; k++) tick();
        check("second_walk_done", 64'(a_rsp_valid), 64'(1));
        check("second_walk_count", 64'(a_wb_count), 64'(0));
        flush_rsp_ready = 1'b1;
        tick();
        flush_rsp_ready = 1'b0;

        // Reset asserted while a writeback at set 7 is pending
        a_req_valid = 1'b1;
        tick();
        a_req_valid = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            eviction = 1'b0;
            wb_req_ready = 1'b0;
            if (a_wb_valid) begin
                found = 1'b1;
            end else begin
                if (a_line && a_line_sel == 5'd7 && a_way_sel == 2'b01) begin
                    eviction = 1'b1;
                    evicted_tag = 23'h1234;
                end
                tick();
            end
        end
        check("rst_test_in_wb", 64'(a_wb_valid), 64'(1));
        check("rst_test_wb_addr", 64'(a_wb_addr), 64'({23'h1234, 5'd7}));
        #2 reset = 1'b0;
        #1;
        check("async_wb_valid", 64'(a_wb_valid), 64'(0));
        check("async_busy", 64'(a_busy), 64'(0));
        check("async_req_ready", 64'(a_req_ready), 64'(1));
        check("async_line", 64'(a_line), 64'(0));
        tick();
        reset = 1'b1;
        tick(); tick();
        check("post_rst_ready", 64'(a_req_ready), 64'(1));
        check("post_rst_busy", 64'(a_busy), 64'(0));
        check("post_rst_wb_valid", 64'(a_wb_valid), 64'(0));
        check("post_rst_rsp_valid", 64'(a_rsp_valid), 64'(0));

        // Single way, every access evicting, writeback always ready
        use_b = 1'b1;
        #1;
        do_walk(1'b0, 0, 2, 0, 65, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vx_cache_flush_walker.md
# vx_cache_flush_walker

Per-bank flush sequencer that drives the flush side of a writeback cache tag store. On a flush request it walks every set and way and asserts `flush_line`/`flush_way_sel` to invalidate each entry. When the tag store reports a dirty eviction, it captures the evicted tag and issues one line writeback request to the bank's memory-side path. It reports completion with a dirty-line count and sits beside the bank pipeline's arbiter, which grants it tag-store access.

## Interface
- `CACHE_SIZE`, 1024, cache size in bytes
- `LINE_SIZE`, 16, line size in bytes
- `NUM_BANKS`, 1, number of banks
- `NUM_WAYS`, 1, associativity (≥1)
- `WORD_SIZE`, 1, word size in bytes (used only by the `CS_*` macros)
- Derived: `L` = `CS_LINES_PER_BANK`; `CW` = `$clog2(L*NUM_WAYS+1)`

Ports:
- `clk` in 1: clock
- `reset` in 1: asynchronous, active-low (0 = reset)
- `flush_req_valid` in 1 / `flush_req_ready` out 1: start handshake
- `flush_rsp_valid` out 1 / `flush_rsp_ready` in 1: completion handshake
- `flush_rsp_wb_count` out CW: number of dirty lines written back, held while `flush_rsp_valid`=1
- `flush_line` out 1: flush access to the tag store
- `flush_way_sel` out NUM_WAYS: one-hot way being flushed
- `flush_line_sel` out `CS_LINE_SEL_BITS`: set index
- `flush_stall` in 1: tag-store access not granted this cycle
- `eviction` in 1: the flushed way is valid and dirty (same cycle as the access)
- `evicted_tag` in `CS_TAG_SEL_BITS`: tag of the flushed way
- `wb_req_valid` out 1 / `wb_req_ready` in 1: writeback handshake
- `wb_req_line_addr` out `CS_LINE_ADDR_WIDTH`: {captured tag, set}
- `wb_req_way` out NUM_WAYS: one-hot way, so the data store can read the line
- `busy` out 1: high in every state except IDLE

## Operation
- States: IDLE, ISSUE, WB, DONE.
- IDLE:
  - `flush_req_ready`=1.
  - When `flush_req_valid`=1: set counter=0, way=0, wb_count=0, then go to ISSUE.
- ISSUE:
  - Drive `flush_line`=1, `flush_way_sel`=1<<way, `flush_line_sel`=set.
  - If `flush_stall`=1: hold all outputs and counters unchanged.
  - Otherwise the access is accepted and `eviction`/`evicted_tag` are sampled in that same cycle:
    - `eviction`=1: capture {tag, set, way}, increment wb_count, go to WB.
    - `eviction`=0: advance.
- WB:
  - `flush_line`=0, `wb_req_valid`=1.
  - Address and way are held stable until `wb_req_ready`=1, then advance.
- Advance:
  - If way==NUM_WAYS-1: way=0 and set=set+1; otherwise way=way+1.
  - If the access just completed was set L-1, way NUM_WAYS-1, go to DONE instead.
- DONE:
  - `flush_rsp_valid`=1 and `flush_rsp_wb_count` held.
  - When `flush_rsp_ready`=1, go to IDLE.
- `flush_req_ready`=0 outside IDLE. Requests presented during a walk are not queued.
- wb_count never exceeds L*NUM_WAYS, so CW bits cannot overflow.
- NUM_WAYS=1: the way counter is constant 0 and `flush_way_sel`=1.
- Reset asserted at any time, including mid-walk or mid-WB:
  - Go to IDLE immediately and drop all valids.
  - Partially flushed tag state is left as is, and no writeback is replayed.

## Timing
- Reset values:
  - `flush_req_ready`=1.
  - All other outputs 0: `flush_rsp_valid`, `flush_line`, `flush_way_sel`, `flush_line_sel`, `wb_req_valid`, `wb_req_line_addr`, `wb_req_way`, `flush_rsp_wb_count`, `busy`.
- All outputs are registered or derived only from state registers. There is no combinational path from any input to any valid output.
- Cycle numbering: the `flush_req` fire is cycle 0 and the first ISSUE is cycle 1.
- Clean walk with no stalls and no evictions: L*NUM_WAYS ISSUE cycles, then `flush_rsp_valid` rises in cycle L*NUM_WAYS+1.
- Each eviction adds at least 1 WB cycle, plus one cycle per cycle `wb_req_ready` is low.
- Each `flush_stall` cycle adds 1 cycle.
- Exactly one `flush_line` acceptance per (set, way) per flush, and exactly one `wb_req` fire per sampled eviction.
- `flush_line`=1 and `wb_req_valid`=1 are never high in the same cycle.

## Test plan
- NUM_WAYS=2, CACHE_SIZE=1024, LINE_SIZE=16 (L=32), `eviction` tied 0, no stalls:
  - Sets are visited 0..31 with way order 01,10.
  - `flush_rsp_valid` rises at cycle 65 with wb_count=0.
- Same config, `eviction`=1 only at set 5 way 1 with `evicted_tag`=0x3A, `wb_req_ready` low for 3 cycles:
  - `wb_req_line_addr`={0x3A,5}, `wb_req_way`=10, held for 4 cycles.
  - Exactly one fire, wb_count=1, completion at cycle 69.
- `flush_stall` high on alternate ISSUE cycles: every (set, way) is accepted exactly once, in order, and completion lands at cycle 129.
- Reset driven low during WB at set 7: all valids drop asynchronously, and after release the block is in IDLE with `flush_req_ready`=1.
- `flush_req_valid` held high through a walk, `flush_rsp_ready` held low for 5 cycles in DONE:
  - `flush_rsp_valid` and the count are held.
  - A second walk starts only after the rsp fire.
- NUM_WAYS=1, every access evicting with `wb_req_ready`=1: 64 cycles total, wb_count=32, `flush_way_sel`=1 throughout.
